vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 124 ++++++++++++
 tb/tb_vga_sync_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing with counters, syncs, active-video flag and frame pulse/count.
// Define VGA_PIX_DIV_EN to advance the raster on every second clk (clk = 2x pixel clock).
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Flag values matching the decode of (0,0), loaded while in reset.
  localparam logic HSYNC_RST = !((H_ACTIVE + H_FP == 0) && (H_SYNC != 0));
  localparam logic VSYNC_RST = !((V_ACTIVE + V_FP == 0) && (V_SYNC != 0));
  localparam logic VIDEO_RST = (H_ACTIVE != 0) && (V_ACTIVE != 0);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic        frame_start_q;
  logic        frame_wrap;
  logic [15:0] frame_count_q, frame_count_d;
  logic        advance;

`ifdef VGA_PIX_DIV_EN
  logic phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
    end
  end

  assign advance = phase_q;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    frame_wrap = 1'b0;
    if (advance) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Flags decode the next-state counters so they land on the same edge as x/y.
  always_comb begin
    hsync_d       = !((x_d >= HS_BEG) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_BEG) && (y_d < VS_END));
    video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
    frame_count_d = frame_count_q + {15'd0, frame_wrap};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= HSYNC_RST;
      vsync_q       <= VSYNC_RST;
      video_on_q    <= VIDEO_RST;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_wrap;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_tick    = advance;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size instance for line timing, shrunken instance for frames.
// Honours VGA_PIX_DIV_EN by scaling all cycle expectations by the pixel divider.
module tb_vga_sync_gen;

`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Shrunken raster so whole frames fit in a short run.
  localparam int S_HA = 40, S_HF = 4, S_HS = 6, S_HB = 4;
  localparam int S_VA = 30, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_HT = 54;
  localparam int S_VT = 39;
  localparam int S_P  = S_HT * S_VT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0]  b_x, b_y, s_x, s_y;
  logic        b_hs, b_vs, b_vo, b_pt, b_fs;
  logic        s_hs, s_vs, s_vo, s_pt, s_fs;
  logic [15:0] b_fc, s_fc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_big (
    .clk(clk), .rst(rst), .x(b_x), .y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .pix_tick(b_pt), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .clk(clk), .rst(rst), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_vo), .pix_tick(s_pt), .frame_start(s_fs), .frame_count(s_fc)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_x !== 10'd0 || b_y !== 10'd0 || b_hs !== 1'b1 || b_vs !== 1'b1 || b_vo !== 1'b1 ||
          b_fs !== 1'b0 || b_fc !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_hold cyc=%0d got x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b fc=%0d exp 0 0 1 1 1 0 0",
                 i, b_x, b_y, b_hs, b_vs, b_vo, b_fs, b_fc);
      end
      n_checks++;
      if (b_pt !== 1'(DIV == 1)) begin
        n_errors++;
        $display("FAIL reset_tick got=%b exp=%b", b_pt, 1'(DIV == 1));
      end
    end
    rst = 1'b0;
    n_checks++;
    if (b_x !== 10'd0 || b_fs !== 1'b0 || s_x !== 10'd0 || s_fc !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_release got bx=%0d bfs=%b sx=%0d sfc=%0d exp 0 0 0 0", b_x, b_fs, s_x, s_fc);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (b_x !== 10'(k / DIV) || b_y !== 10'd0 || b_fs !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_first_adv k=%0d got x=%0d y=%0d fs=%b exp x=%0d y=0 fs=0",
                 k, b_x, b_y, b_fs, k / DIV);
      end
    end
  endtask

  task automatic test_line_wrap();
    int hs_low = 0, vo_hi = 0;
    do_reset();
    for (int k = 1; k <= 802 * DIV; k++) begin
      int pos, ex, ey;
      logic exp_hs, exp_vo;
      @(negedge clk);
      pos    = k / DIV;
      ex     = pos % 800;
      ey     = pos / 800;
      exp_hs = !(ex >= 656 && ex < 752);
      exp_vo = (ex < 640);
      n_checks++;
      if (b_x !== 10'(ex) || b_y !== 10'(ey)) begin
        n_errors++;
        $display("FAIL line_pos k=%0d got (%0d,%0d) exp (%0d,%0d)", k, b_x, b_y, ex, ey);
      end
      n_checks++;
      if (b_hs !== exp_hs || b_vo !== exp_vo || b_vs !== 1'b1) begin
        n_errors++;
        $display("FAIL line_flags x=%0d got hs=%b vo=%b vs=%b exp hs=%b vo=%b vs=1",
                 ex, b_hs, b_vo, b_vs, exp_hs, exp_vo);
      end
      if (k <= 800 * DIV) begin
        if (!b_hs) hs_low++;
        if (b_vo) vo_hi++;
      end
    end
    n_checks++;
    if (hs_low != 96 * DIV) begin
      n_errors++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_low, 96 * DIV);
    end
    n_checks++;
    if (vo_hi != 640 * DIV) begin
      n_errors++;
      $display("FAIL active_width got=%0d exp=%0d", vo_hi, 640 * DIV);
    end
  endtask

  task automatic test_vsync();
    int vs_low = 0, vo_hi = 0, fs_cnt = 0;
    do_reset();
    for (int k = 1; k <= (S_P + S_HT) * DIV; k++) begin
      int pos, ex, ey;
      logic exp_hs, exp_vs, exp_vo, exp_fs, exp_pt;
      @(negedge clk);
      pos    = (k / DIV) % S_P;
      ex     = pos % S_HT;
      ey     = pos / S_HT;
      exp_hs = !(ex >= S_HA + S_HF && ex < S_HA + S_HF + S_HS);
      exp_vs = !(ey >= S_VA + S_VF && ey < S_VA + S_VF + S_VS);
      exp_vo = (ex < S_HA) && (ey < S_VA);
      exp_fs = ((k % (DIV * S_P)) == 0);
      exp_pt = (DIV == 1) ? 1'b1 : 1'(k % 2);
      n_checks++;
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) begin
        n_errors++;
        $display("FAIL frame_pos k=%0d got (%0d,%0d) exp (%0d,%0d)", k, s_x, s_y, ex, ey);
      end
      n_checks++;
      if (s_hs !== exp_hs || s_vs !== exp_vs || s_vo !== exp_vo) begin
        n_errors++;
        $display("FAIL frame_flags (%0d,%0d) got hs=%b vs=%b vo=%b exp hs=%b vs=%b vo=%b",
                 ex, ey, s_hs, s_vs, s_vo, exp_hs, exp_vs, exp_vo);
      end
      n_checks++;
      if (s_fs !== exp_fs || s_pt !== exp_pt) begin
        n_errors++;
        $display("FAIL frame_pulse k=%0d got fs=%b tick=%b exp fs=%b tick=%b",
                 k, s_fs, s_pt, exp_fs, exp_pt);
      end
      if (k <= S_P * DIV) begin
        if (!s_vs) vs_low++;
        if (s_vo) vo_hi++;
        if (s_fs) fs_cnt++;
      end
    end
    n_checks++;
    if (vs_low != S_VS * S_HT * DIV) begin
      n_errors++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * S_HT * DIV);
    end
    n_checks++;
    if (vo_hi != S_HA * S_VA * DIV || fs_cnt != 1) begin
      n_errors++;
      $display("FAIL frame_totals got vo=%0d fs=%0d exp vo=%0d fs=1", vo_hi, fs_cnt, S_HA * S_VA * DIV);
    end
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    do_reset();
    for (int k = 1; k <= 3 * S_P * DIV + 2 * DIV; k++) begin
      @(negedge clk);
      if (s_fs) begin
        pulses++;
        n_checks++;
        if (k != pulses * S_P * DIV || s_fc !== 16'(pulses) || s_x !== 10'd0 || s_y !== 10'd0) begin
          n_errors++;
          $display("FAIL frame_wrap pulse=%0d got k=%0d fc=%0d (%0d,%0d) exp k=%0d fc=%0d (0,0)",
                   pulses, k, s_fc, s_x, s_y, pulses * S_P * DIV, pulses);
        end
      end
    end
    n_checks++;
    if (pulses != 3 || s_fc !== 16'd3) begin
      n_errors++;
      $display("FAIL frame_count3 got pulses=%0d fc=%0d exp 3 3", pulses, s_fc);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    do_reset();
    for (int k = 1; k <= 7 * S_P * DIV && !found; k++) begin
      @(negedge clk);
      if (s_fc == 16'd5 && s_x == 10'd20 && s_y == 10'd15) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL mid_reach got fc=%0d (%0d,%0d) exp fc=5 (20,15)", s_fc, s_x, s_y);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_fc !== 16'd0 || s_fs !== 1'b0 ||
        s_hs !== 1'b1 || s_vs !== 1'b1 || s_vo !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset got (%0d,%0d) fc=%0d fs=%b hs=%b vs=%b vo=%b exp (0,0) 0 0 1 1 1",
               s_x, s_y, s_fc, s_fs, s_hs, s_vs, s_vo);
    end
    rst = 1'b0;
    for (int k = 1; k <= 2 * S_HT * DIV; k++) begin
      int pos;
      @(negedge clk);
      pos = k / DIV;
      n_checks++;
      if (s_x !== 10'(pos % S_HT) || s_y !== 10'(pos / S_HT) || s_fs !== 1'b0 || s_fc !== 16'd0) begin
        n_errors++;
        $display("FAIL mid_resume k=%0d got (%0d,%0d) fs=%b fc=%0d exp (%0d,%0d) 0 0",
                 k, s_x, s_y, s_fs, s_fc, pos % S_HT, pos / S_HT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_vsync();
    test_frame_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
